// File: rtl/lea_pkg.sv
// Shared definitions for the digit-serial add/subtract block:
// the controller state encoding and the default datapath geometry.
package lea_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_DIGIT = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

endpackage

// File: rtl/lea_digit_adder.sv
// One DIGIT-bit slice of the serial adder: combinational sum plus carry-out.
module lea_digit_adder #(
   parameter int DIGIT = 8
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};

endmodule

// File: rtl/lea_digit_addsub.sv
// Digit-serial unsigned add/subtract: one DIGIT-bit slice per cycle, LSB first,
// with a valid/ready handshake on both the operand and the result side.
module lea_digit_addsub
   import lea_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DIGIT = DEFAULT_DIGIT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cb_out
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   generate
      if (WIDTH % DIGIT != 0) begin : g_bad_geometry
         $error("lea_digit_addsub: WIDTH must be a multiple of DIGIT");
      end
   endgenerate

   state_t           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             carry;
   logic             sub_reg;
   logic [CW-1:0]    cnt;
   logic [DIGIT-1:0] sum;
   logic             cout;
   logic [WIDTH-1:0] result_next;

   lea_digit_adder #(
      .DIGIT(DIGIT)
   ) u_adder (
      .a   (a_reg[DIGIT-1:0]),
      .b   (b_reg[DIGIT-1:0]),
      .cin (carry),
      .sum (sum),
      .cout(cout)
   );

   // Each new slice enters at the MSB end so that after N cycles the LSB slice has reached bit 0.
   generate
      if (N == 1) begin : g_single
         assign result_next = sum;
      end else begin : g_multi
         assign result_next = {sum, result[WIDTH-1:DIGIT]};
      end
   endgenerate

   // Subtraction is A + ~B + 1, so the final carry is the inverse of the borrow.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         cb_out    <= 1'b0;
         cnt       <= '0;
         carry     <= 1'b0;
         sub_reg   <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg    <= a;
                  b_reg    <= op_sub ? ~b : b;
                  carry    <= op_sub;
                  sub_reg  <= op_sub;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               a_reg  <= a_reg >> DIGIT;
               b_reg  <= b_reg >> DIGIT;
               carry  <= cout;
               result <= result_next;
               if (cnt == LAST) begin
                  cnt       <= '0;
                  cb_out    <= cout ^ sub_reg;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lea_digit_addsub.sv
// Bench for lea_digit_addsub: a 32/8 instance and a 32/32 instance, each
// checked against an arithmetic reference model through a result queue.
module tb_lea_digit_addsub;

   logic        clk = 1'b0;
   logic        rst;

   logic        in_valid0, in_ready0, op_sub0, out_valid0, out_ready0, cb_out0;
   logic [31:0] a0, b0, result0;
   logic        in_valid1, in_ready1, op_sub1, out_valid1, out_ready1, cb_out1;
   logic [31:0] a1, b1, result1;

   int total = 0;
   int bad   = 0;

   logic [32:0] q0[$];
   logic [32:0] q1[$];

   always #5 clk = ~clk;

   lea_digit_addsub #(.WIDTH(32), .DIGIT(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
      .op_sub(op_sub0), .a(a0), .b(b0), .out_valid(out_valid0),
      .out_ready(out_ready0), .result(result0), .cb_out(cb_out0)
   );

   lea_digit_addsub #(.WIDTH(32), .DIGIT(32)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .op_sub(op_sub1), .a(a1), .b(b1), .out_valid(out_valid1),
      .out_ready(out_ready1), .result(result1), .cb_out(cb_out1)
   );

   function automatic logic [32:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
      if (s) return {x < y, x - y};
      return {1'b0, x} + {1'b0, y};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accepts happen on the edge after in_valid is seen with in_ready high; results leave on out_valid && out_ready.
   always @(negedge clk) begin
      if (!rst) begin
         if (in_valid0 && in_ready0) q0.push_back(model(op_sub0, a0, b0));
         if (out_valid0 && out_ready0) begin
            if (q0.size() == 0) check("unexpected_out0", 64'(out_valid0), 64'd0);
            else check("result0", 64'({cb_out0, result0}), 64'(q0.pop_front()));
         end
         if (out_valid0) check("excl0", 64'(in_ready0), 64'd0);
         if (in_valid1 && in_ready1) q1.push_back(model(op_sub1, a1, b1));
         if (out_valid1 && out_ready1) begin
            if (q1.size() == 0) check("unexpected_out1", 64'(out_valid1), 64'd0);
            else check("result1", 64'({cb_out1, result1}), 64'(q1.pop_front()));
         end
      end
   end

   task automatic do_op0(input logic s, input logic [31:0] x, input logic [31:0] y, output int lat);
      in_valid0 = 1'b1; op_sub0 = s; a0 = x; b0 = y;
      tick();
      in_valid0 = 1'b0;
      lat = 1;
      while (!out_valid0 && lat < 50) begin
         tick();
         lat++;
      end
   endtask

   task automatic do_op1(input logic s, input logic [31:0] x, input logic [31:0] y, output int lat);
      in_valid1 = 1'b1; op_sub1 = s; a1 = x; b1 = y;
      tick();
      in_valid1 = 1'b0;
      lat = 1;
      while (!out_valid1 && lat < 50) begin
         tick();
         lat++;
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, cyc, last, stalls, ops, saw;
      rst = 1'b1;
      in_valid0 = 0; op_sub0 = 0; a0 = 0; b0 = 0; out_ready0 = 1;
      in_valid1 = 0; op_sub1 = 0; a1 = 0; b1 = 0; out_ready1 = 1;
      repeat (3) tick();
      check("rst_out_valid", 64'(out_valid0), 64'd0);
      check("rst_result", 64'(result0), 64'd0);
      check("rst_cb_out", 64'(cb_out0), 64'd0);
      rst = 1'b0;
      tick();
      check("rst_in_ready", 64'(in_ready0), 64'd1);

      // Directed arithmetic with latency checks
      do_op0(1'b1, 32'h0000_0005, 32'h0000_0007, lat);
      check("lat_sub", 64'(lat), 64'd5);
      check("sub_direct", 64'({cb_out0, result0}), 64'h1_FFFF_FFFE);
      tick();
      do_op0(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, lat);
      check("lat_add_wrap", 64'(lat), 64'd5);
      tick();
      do_op0(1'b0, 32'h1234_5678, 32'h1111_1111, lat);
      check("add_direct", 64'({cb_out0, result0}), 64'h0_2345_6789);
      tick();
      do_op0(1'b1, 32'h0000_1234, 32'h0000_1234, lat);
      tick();

      // Result held while consumer stalls; new operands ignored
      out_ready0 = 1'b0;
      do_op0(1'b0, 32'hA5A5_0000, 32'h0000_5A5A, lat);
      check("lat_stall", 64'(lat), 64'd5);
      for (int i = 0; i < 10; i++) begin
         in_valid0 = 1'b1; a0 = $urandom; b0 = $urandom; op_sub0 = 1'($urandom);
         tick();
         check("hold_valid", 64'(out_valid0), 64'd1);
         check("hold_result", 64'(result0), 64'hA5A5_5A5A);
         check("hold_cb", 64'(cb_out0), 64'd0);
         check("hold_in_ready", 64'(in_ready0), 64'd0);
      end
      in_valid0 = 1'b0; out_ready0 = 1'b1;
      tick();
      check("release_in_ready", 64'(in_ready0), 64'd1);
      check("release_out_valid", 64'(out_valid0), 64'd0);

      // Reset in the second RUN cycle aborts the operation
      in_valid0 = 1'b1; op_sub0 = 0; a0 = 32'h0F0F_0F0F; b0 = 32'h0101_0101;
      tick();
      in_valid0 = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check("abort_in_ready", 64'(in_ready0), 64'd1);
      check("abort_out_valid", 64'(out_valid0), 64'd0);
      rst = 1'b0;
      q0.delete();
      q1.delete();
      saw = 0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid0) saw = 1;
         tick();
      end
      check("abort_no_valid", 64'(saw), 64'd0);
      do_op0(1'b1, 32'h0000_0000, 32'h0000_0001, lat);
      check("lat_after_abort", 64'(lat), 64'd5);
      tick();

      // Single-digit instance
      do_op1(1'b1, 32'h8000_0000, 32'h0000_0001, lat);
      check("lat_n1", 64'(lat), 64'd2);
      check("n1_direct", 64'({cb_out1, result1}), 64'h0_7FFF_FFFF);
      tick();
      do_op1(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
      check("lat_n1_add", 64'(lat), 64'd2);
      tick();
      do_op1(1'b1, 32'h0000_0001, 32'h8000_0000, lat);
      tick();

      // Back-to-back random operations with random consumer stalls
      cyc = 0; last = -1; stalls = 0; ops = 0;
      in_valid0 = 1'b1; a0 = $urandom; b0 = $urandom; op_sub0 = 1'($urandom);
      while (ops < 1000 && cyc < 30000) begin
         int accepted;
         accepted = 0;
         out_ready0 = 1'($urandom_range(0, 1));
         if (out_valid0 && !out_ready0) stalls++;
         if (in_ready0) begin
            if (last >= 0) check("period", 64'(cyc - last), 64'(4 + 2 + stalls));
            last = cyc; stalls = 0; ops++; accepted = 1;
         end
         tick();
         cyc++;
         if (accepted) begin
            a0 = $urandom; b0 = $urandom; op_sub0 = 1'($urandom);
            if ($urandom_range(0, 15) == 0) a0 = b0;
            if (ops == 1000) in_valid0 = 1'b0;
         end
      end
      check("random_ops_done", 64'(ops), 64'd1000);
      in_valid0 = 1'b0; out_ready0 = 1'b1;
      for (int i = 0; i < 50 && q0.size() != 0; i++) tick();
      tick();
      check("queue0_empty", 64'(q0.size()), 64'd0);
      check("queue1_empty", 64'(q1.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lea_digit_addsub.md
LEA_DIGIT_ADDSUB -- requirements
Module: lea_digit_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 8, bits processed per cycle; WIDTH SHALL be a multiple of DIGIT (elaboration error otherwise).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, operands and op_sub valid.
REQ-006 SHALL have port in_ready, output, 1, block accepts a new operation.
REQ-007 SHALL have port op_sub, input, 1, 1 = A-B, 0 = A+B.
REQ-008 SHALL have port a, input, WIDTH, minuend/addend A.
REQ-009 SHALL have port b, input, WIDTH, subtrahend/addend B.
REQ-010 SHALL have port out_valid, output, 1, result and flag valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-012 SHALL have port result, output, WIDTH, (A op B) mod 2^WIDTH.
REQ-013 SHALL have port cb_out, output, 1, carry-out for add, borrow-out for sub (1 when A<B unsigned).

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 In IDLE, in_ready=1 and out_valid=0; in_valid=1 SHALL capture a, b, op_sub, clear digit counter, go to RUN.
REQ-016 Capture SHALL store b inverted when op_sub=1 and preset the internal carry to op_sub (A + ~B + 1).
REQ-017 In RUN, in_ready=0; each cycle SHALL add one DIGIT-bit slice, LSB slice first, carry chained to next slice via a register.
REQ-018 RUN SHALL last exactly N=WIDTH/DIGIT cycles; counter wraps to 0 at N-1, then go to DONE.
REQ-019 Latency SHALL be N+1 cycles from accepting edge to out_valid=1 (32/8 -> 5).
REQ-020 In DONE, out_valid=1, result and cb_out stable; cb_out = final carry for add, NOT final carry for sub.
REQ-021 DONE SHALL hold until out_ready=1, then return to IDLE next edge; out_valid and in_ready never both 1.
REQ-022 in_valid, a, b, op_sub changes during RUN/DONE SHALL be ignored.
REQ-023 out_ready while not in DONE SHALL be ignored.
REQ-024 N=1 (DIGIT=WIDTH) SHALL work: one RUN cycle, latency 2.
REQ-025 Arithmetic SHALL be unsigned modulo 2^WIDTH; no saturation, no overflow flag.

Reset
REQ-026 rst=1 SHALL force IDLE, out_valid=0, in_ready=1 (after release), result=0, cb_out=0, counter=0, carry=0.
REQ-027 rst during RUN or DONE SHALL abort the operation with no out_valid pulse.
REQ-028 rst SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-029 State enum (IDLE/RUN/DONE) and default WIDTH/DIGIT constants SHALL live in shared package lea_pkg.
REQ-030 The per-slice add SHALL be sub-module lea_digit_adder (DIGIT-bit a, b, cin -> sum, cout), purely combinational, instantiated once.
REQ-031 Operands SHALL shift right by DIGIT per RUN cycle; sum slices shift into result from MSB side.

Verification
REQ-032 Sub 0x00000005 - 0x00000007 -> result 0xFFFFFFFE, cb_out=1, out_valid exactly 5 cycles after accept.
REQ-033 Add 0xFFFFFFFF + 0x00000001 -> result 0x00000000, cb_out=1; add 0x12345678 + 0x11111111 -> 0x23456789, cb_out=0.
REQ-034 out_ready held 0 for 10 cycles in DONE -> out_valid, result, cb_out stable; in_ready=0; new in_valid ignored.
REQ-035 rst asserted on 2nd RUN cycle -> next cycle IDLE, in_ready=1, out_valid never asserted, next op correct.
REQ-036 WIDTH=32, DIGIT=32: sub 0x80000000 - 0x00000001 -> 0x7FFFFFFF, cb_out=0, latency 2.
REQ-037 1000 random back-to-back ops, both op_sub values, random out_ready -> match reference model, throughput N+2 cycles per op.
